// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected output-layer MAC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fc_pkg;

    localparam int NC     = 10;                  // output classes
    localparam int PIX_W  = 8;                   // unsigned pixel width
    localparam int W_W    = 8;                   // signed weight width
    localparam int ACC_W  = 32;                  // signed accumulator width
    localparam int ADDR_W = 10;                  // element address width
    localparam int PROD_W = W_W + PIX_W + 1;     // signed weight x zero-extended pixel

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_ARGMAX,
        S_HOLD
    } state_t;

    typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/fc_mac_lane.sv
// One class column: two signed products per cycle accumulated into a wrapping ACC_W sum.
// Latency: products registered one cycle after i_en, accumulator updated the cycle after.
// Backpressure: none; i_clr has priority and also discards the in-flight product.
// Ports: i_clr (start of inference), i_en (pixel/weight data valid this cycle),
//        i_lane2_vld (second element is real), i_w1/i_w2, i_px1/i_px2, o_acc.
module fc_mac_lane import fc_pkg::*; (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_lane2_vld,
    input  logic signed [W_W-1:0]   i_w1,
    input  logic signed [W_W-1:0]   i_w2,
    input  logic [PIX_W-1:0]        i_px1,
    input  logic [PIX_W-1:0]        i_px2,
    output acc_t                    o_acc
);

    logic signed [PROD_W-1:0] w_p1;
    logic signed [PROD_W-1:0] w_p2;
    logic signed [PROD_W-1:0] r_p1;
    logic signed [PROD_W-1:0] r_p2;
    logic                     r_pv;
    acc_t                     r_acc;

    // Pixels are unsigned: zero-extend before the signed multiply.
    assign w_p1 = $signed({{(PROD_W-W_W){i_w1[W_W-1]}}, i_w1})
                * $signed({{(PROD_W-PIX_W){1'b0}}, i_px1});

    // The second lane is masked here so a tail element never contributes,
    // whatever the bank returns for the out-of-range address.
    assign w_p2 = i_lane2_vld
                ? $signed({{(PROD_W-W_W){i_w2[W_W-1]}}, i_w2})
                  * $signed({{(PROD_W-PIX_W){1'b0}}, i_px2})
                : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1  <= '0;
            r_p2  <= '0;
            r_pv  <= 1'b0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_p1  <= '0;
            r_p2  <= '0;
            r_pv  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_p1 <= w_p1;
            r_p2 <= w_p2;
            r_pv <= i_en;
            // Sign-extend both products; the sum wraps modulo 2^ACC_W.
            if (r_pv) begin
                r_acc <= r_acc
                       + {{(ACC_W-PROD_W){r_p1[PROD_W-1]}}, r_p1}
                       + {{(ACC_W-PROD_W){r_p2[PROD_W-1]}}, r_p2};
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fc_mac_sequencer.sv
// Walks the input vector two elements per cycle, accumulates NC dot products, argmax-scans them.
// Latency: out_valid rises P+MEM_LAT+NC+1 cycles after the edge that samples start (P = ceil(N_IN/2)).
// Backpressure: result held in HOLD until out_valid && out_ready; start ignored while busy.
// Ports: start; addr1/addr2/validWeight2 to weight bank and pixel buffer; weights_flat, px1, px2
//        returned MEM_LAT cycles later; busy; sums_flat, class_idx, out_valid/out_ready result.
module fc_mac_sequencer import fc_pkg::*; #(
    parameter int N_IN    = 784,
    parameter int MEM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_W-1:0]       addr1,
    output logic [ADDR_W-1:0]       addr2,
    output logic                    validWeight2,
    input  logic [NC*2*W_W-1:0]     weights_flat,
    input  logic [PIX_W-1:0]        px1,
    input  logic [PIX_W-1:0]        px2,
    output logic                    busy,
    output logic [NC*ACC_W-1:0]     sums_flat,
    output logic [3:0]              class_idx,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int                P          = (N_IN + 1) / 2;
    localparam bit                ODD        = (N_IN % 2) == 1;
    localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(P - 1);
    // Drain covers the memory latency plus the lane product register.
    localparam logic [2:0]        DRAIN_LAST = 3'(MEM_LAT);
    localparam logic [3:0]        SCAN_LAST  = 4'(NC - 1);
    localparam bit                VW2_FIRST  = !(ODD && (P == 1));

    state_t              r_state;
    logic [ADDR_W-1:0]   r_k;
    logic [ADDR_W-1:0]   r_addr1;
    logic [ADDR_W-1:0]   r_addr2;
    logic                r_vw2;
    logic [MEM_LAT-1:0]  r_sr_vld;
    logic [MEM_LAT-1:0]  r_sr_l2;
    logic [2:0]          r_drain;
    logic [3:0]          r_scan;
    logic [3:0]          r_best_idx;
    logic [3:0]          r_class_idx;
    acc_t                r_best;
    logic                r_out_valid;

    logic                w_clr;
    logic                w_push;
    logic [ADDR_W-1:0]   w_k_nxt;
    acc_t                w_acc [NC];
    acc_t                w_cand;
    logic                w_take;

    assign w_clr   = (r_state == S_IDLE) && start;
    assign w_push  = (r_state == S_ISSUE);
    assign w_k_nxt = r_k + ADDR_W'(1);
    assign w_cand  = w_acc[r_scan];
    // Strictly greater keeps the lowest index on ties.
    assign w_take  = (r_scan == 4'd0) || (w_cand > r_best);

    // Tracks which cycle's bank data belongs to an issued pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr_vld <= '0;
            r_sr_l2  <= '0;
        end else begin
            r_sr_vld[0] <= w_push;
            r_sr_l2[0]  <= w_push && r_vw2;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_sr_vld[i] <= r_sr_vld[i-1];
                r_sr_l2[i]  <= r_sr_l2[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_addr1     <= ADDR_W'(0);
            r_addr2     <= ADDR_W'(1);
            r_vw2       <= 1'b1;
            r_drain     <= '0;
            r_scan      <= '0;
            r_best_idx  <= '0;
            r_best      <= '0;
            r_class_idx <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_ISSUE;
                        r_k         <= '0;
                        r_addr1     <= ADDR_W'(0);
                        r_addr2     <= ADDR_W'(1);
                        r_vw2       <= VW2_FIRST;
                        r_class_idx <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                        r_addr1 <= ADDR_W'(0);
                        r_addr2 <= ADDR_W'(1);
                        r_vw2   <= 1'b1;
                    end else begin
                        r_k     <= w_k_nxt;
                        r_addr1 <= {w_k_nxt[ADDR_W-2:0], 1'b0};
                        r_addr2 <= {w_k_nxt[ADDR_W-2:0], 1'b1};
                        // Only the final pair of an odd-length vector has no second element.
                        r_vw2   <= !(ODD && (w_k_nxt == K_LAST));
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= S_ARGMAX;
                        r_scan  <= '0;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                S_ARGMAX: begin
                    if (w_take) begin
                        r_best     <= w_cand;
                        r_best_idx <= r_scan;
                    end
                    if (r_scan == SCAN_LAST) begin
                        r_class_idx <= w_take ? r_scan : r_best_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_scan <= r_scan + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_lane
        fc_mac_lane u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_clr       (w_clr),
            .i_en        (r_sr_vld[MEM_LAT-1]),
            .i_lane2_vld (r_sr_l2[MEM_LAT-1]),
            .i_w1        (weights_flat[(2*c)*W_W +: W_W]),
            .i_w2        (weights_flat[(2*c+1)*W_W +: W_W]),
            .i_px1       (px1),
            .i_px2       (px2),
            .o_acc       (w_acc[c])
        );
        assign sums_flat[c*ACC_W +: ACC_W] = w_acc[c];
    end

    assign addr1        = r_addr1;
    assign addr2        = r_addr2;
    assign validWeight2 = r_vw2;
    assign busy         = (r_state != S_IDLE);
    assign class_idx    = r_class_idx;
    assign out_valid    = r_out_valid;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Scoreboard bench: a default-size sequencer and an N_IN=5 sequencer driven by registered bank models.
// Latency: bank models return data one cycle after the address (MEM_LAT=1).
// Backpressure: out_ready is held low for a while in one scenario.
module tb_fc_mac_sequencer;
    import fc_pkg::*;

    localparam int NIN_A = 784;
    localparam int LAT_A = 404;
    localparam int LAT_B = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                start_a = 1'b0, out_ready_a = 1'b1;
    logic [ADDR_W-1:0]   addr1_a, addr2_a;
    logic                vw2_a, busy_a, ov_a;
    logic [NC*2*W_W-1:0] wf_a;
    logic [PIX_W-1:0]    px1_a, px2_a;
    logic [NC*ACC_W-1:0] sums_a;
    logic [3:0]          idx_a;

    logic                start_b = 1'b0, out_ready_b = 1'b1;
    logic [ADDR_W-1:0]   addr1_b, addr2_b;
    logic                vw2_b, busy_b, ov_b;
    logic [NC*2*W_W-1:0] wf_b;
    logic [PIX_W-1:0]    px1_b, px2_b;
    logic [NC*ACC_W-1:0] sums_b;
    logic [3:0]          idx_b;

    fc_mac_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .addr1(addr1_a), .addr2(addr2_a),
        .validWeight2(vw2_a), .weights_flat(wf_a), .px1(px1_a), .px2(px2_a), .busy(busy_a),
        .sums_flat(sums_a), .class_idx(idx_a), .out_valid(ov_a), .out_ready(out_ready_a)
    );

    fc_mac_sequencer #(.N_IN(5), .MEM_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .addr1(addr1_b), .addr2(addr2_b),
        .validWeight2(vw2_b), .weights_flat(wf_b), .px1(px1_b), .px2(px2_b), .busy(busy_b),
        .sums_flat(sums_b), .class_idx(idx_b), .out_valid(ov_b), .out_ready(out_ready_b)
    );

    // Bank for A: per-class constant weight on both lanes, constant pixel.
    int wa [NC];
    int pa;
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            wf_a[(2*c)*W_W +: W_W]   <= 8'(wa[c]);
            wf_a[(2*c+1)*W_W +: W_W] <= 8'(wa[c]);
        end
        px1_a <= 8'(pa);
        px2_a <= 8'(pa);
    end

    // Bank for B: pixel = element+1, weights 1; out-of-range lane2 returns 0x7F garbage.
    always @(posedge clk) begin
        px1_b <= 8'(addr1_b + 1);
        px2_b <= (addr2_b >= 5) ? 8'h7F : 8'(addr2_b + 1);
        for (int c = 0; c < NC; c++) begin
            wf_b[(2*c)*W_W +: W_W]   <= 8'd1;
            wf_b[(2*c+1)*W_W +: W_W] <= (addr2_b >= 5) ? 8'h7F : 8'd1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        logic [NC*ACC_W-1:0] sums;
        logic [3:0]          idx;
        int                  lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a, e_b;
    int   st_a = 0, st_b = 0;
    logic ov_prev_a = 1'b0, ov_prev_b = 1'b0;
    logic vw2_low_a = 1'b0;

    // Monitors: compare on each rising out_valid against the oldest expectation.
    always @(negedge clk) begin
        if (ov_a && !ov_prev_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", ov_a, 0);
            end else begin
                e_a = qa.pop_front();
                for (int c = 0; c < NC; c++)
                    chk($sformatf("a_sum%0d", c), $signed(sums_a[c*ACC_W +: ACC_W]),
                        $signed(e_a.sums[c*ACC_W +: ACC_W]));
                chk("a_class_idx", idx_a, e_a.idx);
                chk("a_latency", cyc - st_a, e_a.lat);
            end
        end
        ov_prev_a = ov_a;
        if (rst && !vw2_a) vw2_low_a = 1'b1;
    end

    always @(negedge clk) begin
        if (ov_b && !ov_prev_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", ov_b, 0);
            end else begin
                e_b = qb.pop_front();
                for (int c = 0; c < NC; c++)
                    chk($sformatf("b_sum%0d", c), $signed(sums_b[c*ACC_W +: ACC_W]),
                        $signed(e_b.sums[c*ACC_W +: ACC_W]));
                chk("b_class_idx", idx_b, e_b.idx);
                chk("b_latency", cyc - st_b, e_b.lat);
            end
        end
        ov_prev_b = ov_b;
    end

    task automatic push_a(input int exp_idx);
        exp_t e;
        for (int c = 0; c < NC; c++) e.sums[c*ACC_W +: ACC_W] = ACC_W'(NIN_A * wa[c] * pa);
        e.idx = 4'(exp_idx);
        e.lat = LAT_A;
        qa.push_back(e);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        st_a = cyc;
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 1000 && busy_a; i++) @(negedge clk);
        chk({tag, "_done"}, busy_a, 0);
    endtask

    task automatic run_a(input int exp_idx, input string tag);
        push_a(exp_idx);
        pulse_start_a();
        wait_idle_a(tag);
    endtask

    task automatic set_w(input int w_all, input int w3, input int pix);
        for (int c = 0; c < NC; c++) wa[c] = w_all;
        wa[3] = w3;
        pa = pix;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr1"}, addr1_a, 0);
        chk({tag, "_addr2"}, addr2_a, 1);
        chk({tag, "_vw2"}, vw2_a, 1);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_out_valid"}, ov_a, 0);
        chk({tag, "_class_idx"}, idx_a, 0);
        for (int c = 0; c < NC; c++)
            chk($sformatf("%s_sum%0d", tag, c), $signed(sums_a[c*ACC_W +: ACC_W]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int ea1 [3] = '{0, 2, 4};
    int ea2 [3] = '{1, 3, 5};
    int ev  [3] = '{1, 1, 0};

    initial begin
        exp_t eb;
        set_w(1, 1, 1);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(negedge clk) rst = 1'b1;

        // All ones: every sum 784, tie resolves to class 0.
        run_a(0, "ones");
        chk("ones_vw2_never_low", vw2_low_a, 0);

        // Class 3 doubled.
        set_w(1, 2, 1);
        run_a(3, "class3");

        // Most negative weight times max pixel: -25589760, no wrap.
        set_w(-128, -128, 255);
        run_a(0, "neg");

        // Odd length on the N_IN=5 instance.
        for (int c = 0; c < NC; c++) eb.sums[c*ACC_W +: ACC_W] = ACC_W'(15);
        eb.idx = 4'd0;
        eb.lat = LAT_B;
        qb.push_back(eb);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        st_b = cyc;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("odd_pair%0d_addr1", i), addr1_b, ea1[i]);
            chk($sformatf("odd_pair%0d_addr2", i), addr2_b, ea2[i]);
            chk($sformatf("odd_pair%0d_vw2", i), vw2_b, ev[i]);
            @(negedge clk);
        end
        chk("odd_parked_addr1", addr1_b, 0);
        chk("odd_parked_vw2", vw2_b, 1);
        for (int i = 0; i < 100 && busy_b; i++) @(negedge clk);
        chk("odd_done", busy_b, 0);

        // Backpressure: result held, start during HOLD ignored.
        set_w(1, 2, 1);
        out_ready_a = 1'b0;
        push_a(3);
        pulse_start_a();
        for (int i = 0; i < 1000 && !ov_a; i++) @(negedge clk);
        chk("bp_valid_seen", ov_a, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_a = (i == 5);
            chk("bp_hold_valid", ov_a, 1);
            chk("bp_hold_idx", idx_a, 3);
            chk("bp_hold_sum3", $signed(sums_a[3*ACC_W +: ACC_W]), 1568);
            chk("bp_hold_sum0", $signed(sums_a[0 +: ACC_W]), 784);
        end
        @(negedge clk) begin
            start_a = 1'b0;
            out_ready_a = 1'b1;
        end
        @(negedge clk);
        chk("bp_handshake_valid_low", ov_a, 0);
        chk("bp_handshake_idle", busy_a, 0);
        repeat (3) @(negedge clk);
        chk("bp_start_ignored", busy_a, 0);
        run_a(3, "bp_next");

        // Reset in the middle of ISSUE at pair 100.
        set_w(1, 1, 1);
        pulse_start_a();
        for (int i = 0; i < 600 && addr1_a != 200; i++) @(negedge clk);
        chk("abort_reached_pair100", addr1_a, 200);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk) rst = 1'b1;
        run_a(0, "post_abort");

        repeat (5) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
